// File: rtl/decode_stage.sv
// RV32I decode stage with the ID/EX pipeline register and load-use stall.
module decode_stage #(
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic        ValidD,
  input  logic        FlushE,
  output logic [4:0]  A1,
  output logic [4:0]  A2,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  output logic        StallFD,
  output logic        ValidE,
  output logic [31:0] PCE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [2:0]  Funct3E,
  output logic        RegWriteE,
  output logic        MemReadE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        JalrE,
  output logic        ALUSrcAE,
  output logic        ALUSrcBE,
  output logic        IllegalE,
  output logic [3:0]  ALUControlE,
  output logic [1:0]  ResultSrcE
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic        w_f7b5;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  logic        w_regwrite, w_memread, w_memwrite, w_branch, w_jump, w_jalr;
  logic        w_alusrca, w_alusrcb, w_illegal, w_use_rs1, w_use_rs2, w_rd_zero;
  logic [3:0]  w_alu, w_alu_f3;
  logic [1:0]  w_resultsrc;
  logic [31:0] w_imm;
  logic        w_hazard, w_bubble;

  logic        r_valid, r_regwrite, r_memread, r_memwrite, r_branch, r_jump;
  logic        r_jalr, r_alusrca, r_alusrcb, r_illegal;
  logic [31:0] r_pc, r_rd1, r_rd2, r_imm;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [2:0]  r_f3;
  logic [3:0]  r_alu;
  logic [1:0]  r_resultsrc;

  assign w_opcode = InstrD[6:0];
  assign w_rd     = InstrD[11:7];
  assign w_f3     = InstrD[14:12];
  assign w_rs1    = InstrD[19:15];
  assign w_rs2    = InstrD[24:20];
  assign w_f7b5   = InstrD[30];

  assign A1 = w_rs1;
  assign A2 = w_rs2;

  assign w_imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
  assign w_imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign w_imm_b = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign w_imm_u = {InstrD[31:12], 12'h000};
  assign w_imm_j = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

  // ALU op for the arithmetic opcodes; SUB exists only in the R form
  always_comb begin
    w_alu_f3 = ALU_ADD;
    case (w_f3)
      3'b000:  w_alu_f3 = (w_opcode == OP_R && w_f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_f3 = ALU_SLL;
      3'b010:  w_alu_f3 = ALU_SLT;
      3'b011:  w_alu_f3 = ALU_SLTU;
      3'b100:  w_alu_f3 = ALU_XOR;
      3'b101:  w_alu_f3 = w_f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_f3 = ALU_OR;
      default: w_alu_f3 = ALU_AND;
    endcase
  end

  // Main opcode decode: controls, immediate select and register-field usage
  always_comb begin
    w_regwrite  = 1'b0;
    w_memread   = 1'b0;
    w_memwrite  = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_jalr      = 1'b0;
    w_alusrca   = 1'b0;
    w_alusrcb   = 1'b0;
    w_illegal   = 1'b0;
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    w_rd_zero   = 1'b0;
    w_alu       = ALU_ADD;
    w_resultsrc = 2'b00;
    w_imm       = 32'h0;
    case (w_opcode)
      OP_R: begin
        w_regwrite = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_alu = w_alu_f3;
      end
      OP_I: begin
        w_regwrite = 1'b1; w_alusrcb = 1'b1; w_use_rs1 = 1'b1;
        w_alu = w_alu_f3; w_imm = w_imm_i;
      end
      OP_LOAD: begin
        w_regwrite = 1'b1; w_memread = 1'b1; w_alusrcb = 1'b1; w_use_rs1 = 1'b1;
        w_resultsrc = 2'b01; w_imm = w_imm_i;
      end
      OP_STORE: begin
        w_memwrite = 1'b1; w_alusrcb = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_rd_zero = 1'b1; w_imm = w_imm_s;
      end
      OP_BR: begin
        w_branch = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_rd_zero = 1'b1;
        w_alu = ALU_SUB; w_imm = w_imm_b;
      end
      OP_JAL: begin
        w_regwrite = 1'b1; w_jump = 1'b1; w_resultsrc = 2'b10; w_imm = w_imm_j;
      end
      OP_JALR: begin
        w_regwrite = 1'b1; w_jalr = 1'b1; w_alusrcb = 1'b1; w_use_rs1 = 1'b1;
        w_resultsrc = 2'b10; w_imm = w_imm_i;
      end
      OP_LUI: begin
        w_regwrite = 1'b1; w_alusrcb = 1'b1; w_alu = ALU_PASSB; w_imm = w_imm_u;
      end
      OP_AUIPC: begin
        w_regwrite = 1'b1; w_alusrca = 1'b1; w_alusrcb = 1'b1; w_imm = w_imm_u;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // A load in EX whose destination is read by the instruction in D must wait one cycle
  assign w_hazard = (w_use_rs1 && (r_rd == w_rs1)) || (w_use_rs2 && (r_rd == w_rs2));
  assign StallFD  = LOAD_USE_STALL && r_valid && r_memread && (r_rd != 5'd0) &&
                    ValidD && w_hazard;
  assign w_bubble = StallFD || FlushE || !ValidD;

  // ID/EX register; reset and bubble both clear every field
  always_ff @(posedge clk) begin
    if (!rst || w_bubble) begin
      r_valid     <= 1'b0;
      r_pc        <= 32'h0;
      r_rd1       <= 32'h0;
      r_rd2       <= 32'h0;
      r_imm       <= 32'h0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_f3        <= 3'd0;
      r_regwrite  <= 1'b0;
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_jalr      <= 1'b0;
      r_alusrca   <= 1'b0;
      r_alusrcb   <= 1'b0;
      r_illegal   <= 1'b0;
      r_alu       <= 4'd0;
      r_resultsrc <= 2'd0;
    end else begin
      r_valid     <= 1'b1;
      r_pc        <= PCD;
      r_rd1       <= RD1;
      r_rd2       <= RD2;
      r_imm       <= w_imm;
      r_rs1       <= w_use_rs1 ? w_rs1 : 5'd0;
      r_rs2       <= w_use_rs2 ? w_rs2 : 5'd0;
      r_rd        <= w_rd_zero ? 5'd0 : w_rd;
      r_f3        <= w_f3;
      r_regwrite  <= w_regwrite && (w_rd != 5'd0);
      r_memread   <= w_memread;
      r_memwrite  <= w_memwrite;
      r_branch    <= w_branch;
      r_jump      <= w_jump;
      r_jalr      <= w_jalr;
      r_alusrca   <= w_alusrca;
      r_alusrcb   <= w_alusrcb;
      r_illegal   <= w_illegal;
      r_alu       <= w_alu;
      r_resultsrc <= w_resultsrc;
    end
  end

  assign ValidE      = r_valid;
  assign PCE         = r_pc;
  assign RD1E        = r_rd1;
  assign RD2E        = r_rd2;
  assign ImmE        = r_imm;
  assign Rs1E        = r_rs1;
  assign Rs2E        = r_rs2;
  assign RdE         = r_rd;
  assign Funct3E     = r_f3;
  assign RegWriteE   = r_regwrite;
  assign MemReadE    = r_memread;
  assign MemWriteE   = r_memwrite;
  assign BranchE     = r_branch;
  assign JumpE       = r_jump;
  assign JalrE       = r_jalr;
  assign ALUSrcAE    = r_alusrca;
  assign ALUSrcBE    = r_alusrcb;
  assign IllegalE    = r_illegal;
  assign ALUControlE = r_alu;
  assign ResultSrcE  = r_resultsrc;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan steps, then random instructions
// compared against a behavioural model of the decode/ID-EX behaviour.
module tb_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        regwrite, memread, memwrite, branch, jump, jalr, alusrca, alusrcb, illegal;
    logic [3:0]  alu;
    logic [1:0]  resultsrc;
  } ex_t;

  logic        clk, rst;
  logic [31:0] InstrD, PCD, RD1, RD2;
  logic        ValidD, FlushE, StallFD;
  logic [4:0]  A1, A2;
  logic        ValidE;
  logic [31:0] PCE, RD1E, RD2E, ImmE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [2:0]  Funct3E;
  logic        RegWriteE, MemReadE, MemWriteE, BranchE, JumpE, JalrE;
  logic        ALUSrcAE, ALUSrcBE, IllegalE;
  logic [3:0]  ALUControlE;
  logic [1:0]  ResultSrcE;

  int   checks = 0;
  int   errors = 0;
  ex_t  model;
  logic last_stall;
  logic [31:0] pc_ctr;

  logic [3:0] alu_by_f3 [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

  decode_stage #(.LOAD_USE_STALL(1'b1)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD), .FlushE(FlushE),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .StallFD(StallFD),
    .ValidE(ValidE), .PCE(PCE), .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .Funct3E(Funct3E),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .ALUSrcAE(ALUSrcAE),
    .ALUSrcBE(ALUSrcBE), .IllegalE(IllegalE), .ALUControlE(ALUControlE),
    .ResultSrcE(ResultSrcE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_t observed();
    ex_t o;
    o = '{ValidE, PCE, RD1E, RD2E, ImmE, Rs1E, Rs2E, RdE, Funct3E, RegWriteE, MemReadE,
          MemWriteE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE, IllegalE, ALUControlE,
          ResultSrcE};
    return o;
  endfunction

  function automatic logic reads_rs1(logic [31:0] ins);
    return ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic logic reads_rs2(logic [31:0] ins);
    return ins[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  // What the instruction in D should look like once it sits in EX
  function automatic ex_t ref_decode(logic [31:0] ins, logic [31:0] pc,
                                     logic [31:0] d1, logic [31:0] d2);
    ex_t  e;
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, writes;
    is_r     = ins[6:0] == 7'h33;
    is_i     = ins[6:0] == 7'h13;
    is_ld    = ins[6:0] == 7'h03;
    is_st    = ins[6:0] == 7'h23;
    is_br    = ins[6:0] == 7'h63;
    is_jal   = ins[6:0] == 7'h6F;
    is_jalr  = ins[6:0] == 7'h67;
    is_lui   = ins[6:0] == 7'h37;
    is_auipc = ins[6:0] == 7'h17;
    writes   = is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc;
    e = '0;
    e.valid     = 1'b1;
    e.pc        = pc;
    e.rd1       = d1;
    e.rd2       = d2;
    e.funct3    = ins[14:12];
    e.regwrite  = writes && (ins[11:7] != 0);
    e.memread   = is_ld;
    e.memwrite  = is_st;
    e.branch    = is_br;
    e.jump      = is_jal;
    e.jalr      = is_jalr;
    e.alusrca   = is_auipc;
    e.alusrcb   = is_i | is_ld | is_st | is_jalr | is_lui | is_auipc;
    e.illegal   = !(writes | is_st | is_br);
    e.resultsrc = is_ld ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : 2'd0;
    e.rs1       = reads_rs1(ins) ? ins[19:15] : 5'd0;
    e.rs2       = reads_rs2(ins) ? ins[24:20] : 5'd0;
    e.rd        = (is_st | is_br) ? 5'd0 : ins[11:7];
    if (is_br) e.alu = 4'd1;
    else if (is_lui) e.alu = 4'd10;
    else if (is_r | is_i) begin
      e.alu = alu_by_f3[ins[14:12]];
      if (is_r && ins[14:12] == 3'd0 && ins[30]) e.alu = 4'd1;
      if (ins[14:12] == 3'd5 && ins[30]) e.alu = 4'd7;
    end
    if (is_i | is_ld | is_jalr)  e.imm = int'($signed(ins[31:20]));
    else if (is_st)              e.imm = int'($signed({ins[31:25], ins[11:7]}));
    else if (is_br)              e.imm = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    else if (is_lui | is_auipc)  e.imm = {ins[31:12], 12'h000};
    else if (is_jal)             e.imm = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    return e;
  endfunction

  function automatic logic ref_stall(ex_t prev, logic [31:0] ins, logic vd);
    return prev.valid && prev.memread && prev.rd != 0 && vd &&
           ((reads_rs1(ins) && prev.rd == ins[19:15]) || (reads_rs2(ins) && prev.rd == ins[24:20]));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_e(input string tag);
    ex_t o;
    o = observed();
    checks++;
    assert (o === model) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, o, model);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic vd, input logic fl);
    InstrD = ins;
    PCD    = pc_ctr;
    ValidD = vd;
    FlushE = fl;
    RD1    = $urandom;
    RD2    = $urandom;
    pc_ctr = pc_ctr + 32'd4;
  endtask

  // One pipeline cycle with rst high: check D-side combinational outputs, then EX
  task automatic step(input logic [31:0] ins, input logic vd, input logic fl, input string tag);
    logic exp_stall;
    ex_t  nxt;
    drive(ins, vd, fl);
    #1;
    exp_stall  = ref_stall(model, ins, vd);
    last_stall = StallFD;
    chk({tag, "_stall"}, {31'd0, StallFD}, {31'd0, exp_stall});
    chk({tag, "_a1a2"}, {22'd0, A1, A2}, {22'd0, ins[19:15], ins[24:20]});
    nxt = (exp_stall || fl || !vd) ? '0 : ref_decode(ins, PCD, RD1, RD2);
    @(posedge clk);
    #1;
    model = nxt;
    chk_e({tag, "_ex"});
  endtask

  task automatic reset_step(input logic [31:0] ins, input logic check_pre, input string tag);
    rst = 1'b0;
    drive(ins, 1'b1, 1'b0);
    #1;
    if (check_pre)
      chk({tag, "_prestall"}, {31'd0, StallFD}, {31'd0, ref_stall(model, ins, 1'b1)});
    @(posedge clk);
    #1;
    model = '0;
    chk_e({tag, "_ex"});
    chk({tag, "_stall"}, {31'd0, StallFD}, 32'd0);
  endtask

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] SUB   = 32'h40208133;
  localparam logic [31:0] BEQ   = 32'hFE208EE3;
  localparam logic [31:0] LUI0  = 32'h12345037;
  localparam logic [31:0] LW5   = 32'h0000A283;
  localparam logic [31:0] ADD6  = 32'h00328333;
  localparam logic [31:0] ADDI6 = 32'h00138313;
  localparam logic [31:0] LW0   = 32'h0000A003;
  localparam logic [31:0] ADDX0 = 32'h00000333;

  initial begin
    logic [31:0] ins;
    model  = '0;
    pc_ctr = 32'h0000_1000;
    last_stall = 1'b0;
    rst = 1'b0;
    InstrD = 32'h0; PCD = 32'h0; ValidD = 1'b0; FlushE = 1'b0; RD1 = 32'h0; RD2 = 32'h0;

    reset_step(ADDI, 1'b0, "rst0");
    reset_step(ADDI, 1'b1, "rst1");
    rst = 1'b1;

    step(ADDI, 1'b1, 1'b0, "addi");
    chk("addi_valid", {31'd0, ValidE}, 32'd1);
    chk("addi_rd", {27'd0, RdE}, 32'd1);
    chk("addi_imm", ImmE, 32'd5);
    chk("addi_alu", {28'd0, ALUControlE}, 32'd0);

    step(SUB, 1'b1, 1'b0, "sub");
    chk("sub_alu", {28'd0, ALUControlE}, 32'd1);
    chk("sub_rs", {22'd0, Rs1E, Rs2E}, {22'd0, 5'd1, 5'd2});

    step(BEQ, 1'b1, 1'b0, "beq");
    chk("beq_imm", ImmE, 32'hFFFF_FFFC);
    chk("beq_br_rd", {26'd0, BranchE, RdE}, {26'd0, 1'b1, 5'd0});

    step(LUI0, 1'b1, 1'b0, "lui0");
    chk("lui0_regwrite", {31'd0, RegWriteE}, 32'd0);

    step(LW5, 1'b1, 1'b0, "lw5");
    step(ADD6, 1'b1, 1'b0, "lu_add");
    chk("lu_stall_hi", {31'd0, last_stall}, 32'd1);
    chk("lu_bubble", {31'd0, ValidE}, 32'd0);
    step(ADD6, 1'b1, 1'b0, "lu_add2");
    chk("lu_release", {31'd0, last_stall}, 32'd0);
    chk("lu_add_in_e", {26'd0, ValidE, RdE}, {26'd0, 1'b1, 5'd6});

    step(LW5, 1'b1, 1'b0, "lw5b");
    step(ADDI6, 1'b1, 1'b0, "nostall_addi");
    chk("nostall_addi_s", {31'd0, last_stall}, 32'd0);

    step(LW0, 1'b1, 1'b0, "lwx0");
    step(ADDX0, 1'b1, 1'b0, "nostall_x0");
    chk("nostall_x0_s", {31'd0, last_stall}, 32'd0);

    step(ADD6, 1'b1, 1'b1, "flush");
    chk("flush_v_rw", {30'd0, ValidE, RegWriteE}, 32'd0);

    step(LW5, 1'b1, 1'b0, "lw5c");
    step(ADD6, 1'b1, 1'b1, "flush_stall");
    chk("flush_stall_s", {31'd0, last_stall}, 32'd1);
    chk("flush_stall_v", {31'd0, ValidE}, 32'd0);
    step(ADD6, 1'b1, 1'b0, "after_fs");
    chk("after_fs_v", {31'd0, ValidE}, 32'd1);

    step(32'hFFFF_FFFF, 1'b1, 1'b0, "illegal");
    chk("illegal_flags", {28'd0, IllegalE, RegWriteE, MemWriteE, MemReadE}, 32'h8);

    step(LW5, 1'b1, 1'b0, "lw5d");
    reset_step(ADD6, 1'b1, "rst_mid_stall");
    rst = 1'b1;

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      step(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
